// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes and hazard FSM state type for the core pipeline
package cpu_pkg;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        BUBBLE   = 3'd1,
        MEM_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALT     = 3'd4
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX status in, pipeline stall/flush controls out
interface hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic [3:0]             id_opcode;
    logic [3:0]             id_rs_addr;
    logic [3:0]             id_rt_addr;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic [3:0]             ex_opcode;
    logic [3:0]             ex_rd_addr;
    logic                   ex_WriteReg;
    logic                   ex_branch_taken;
    logic                   mem_busy;
    logic                   pc_stall_n;
    logic                   if_id_stall_n;
    logic                   if_id_flush;
    logic                   id_ex_stall_n;
    logic                   id_ex_flush;
    logic                   ex_mem_stall_n;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_opcode, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_opcode, ex_rd_addr, ex_WriteReg, ex_branch_taken, mem_busy,
        input  pc_stall_n, if_id_stall_n, if_id_flush, id_ex_stall_n,
               id_ex_flush, ex_mem_stall_n, halted, stall_count
    );

    modport slave (
        input  id_opcode, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_opcode, ex_rd_addr, ex_WriteReg, ex_branch_taken, mem_busy,
        output pc_stall_n, if_id_stall_n, if_id_flush, id_ex_stall_n,
               id_ex_flush, ex_mem_stall_n, halted, stall_count
    );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID source register produced by a load still in EX
module load_use_detect
    import cpu_pkg::*;
(
    input  logic [3:0] ex_opcode_i,
    input  logic [3:0] ex_rd_addr_i,
    input  logic       ex_write_reg_i,
    input  logic [3:0] id_rs_addr_i,
    input  logic [3:0] id_rt_addr_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    output logic       hazard_o
);
    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign ex_is_load = (ex_opcode_i == OP_LW) && ex_write_reg_i && (ex_rd_addr_i != 4'd0);
    assign rs_match   = id_uses_rs_i && (id_rs_addr_i == ex_rd_addr_i);
    assign rt_match   = id_uses_rt_i && (id_rt_addr_i == ex_rd_addr_i);
    assign hazard_o   = ex_is_load && (rs_match || rt_match);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush FSM with memory freeze, halt drain and stall counter
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int STALL_CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    hazard_state_t          state_q, state_d;
    hazard_state_t          saved_q, saved_d;
    hazard_state_t          eff_state;
    logic [1:0]             bub_q, bub_d;
    logic [1:0]             drain_q, drain_d;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic                   hazard;
    logic                   unused_id_opcode;

    assign unused_id_opcode = ^bus.id_opcode;

    load_use_detect u_lud (
        .ex_opcode_i    (bus.ex_opcode),
        .ex_rd_addr_i   (bus.ex_rd_addr),
        .ex_write_reg_i (bus.ex_WriteReg),
        .id_rs_addr_i   (bus.id_rs_addr),
        .id_rt_addr_i   (bus.id_rt_addr),
        .id_uses_rs_i   (bus.id_uses_rs),
        .id_uses_rt_i   (bus.id_uses_rt),
        .hazard_o       (hazard)
    );

    // Counters are frozen during MEM_WAIT, so only the interrupted state needs saving
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            bub_q   <= 2'd0;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            bub_q   <= bub_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        bub_d   = bub_q;
        drain_d = drain_q;
        if (state_q != HALT) begin
            if (bus.mem_busy) begin
                state_d = MEM_WAIT;
                saved_d = eff_state;
            end else begin
                state_d = eff_state;
                case (eff_state)
                    RUN: begin
                        if (bus.ex_branch_taken) begin
                            state_d = RUN;
                        end else if (hazard) begin
                            if (LOAD_USE_BUBBLES > 1) begin
                                state_d = BUBBLE;
                                bub_d   = BUB_INIT;
                            end
                        end else if (bus.ex_opcode == OP_HLT) begin
                            state_d = DRAIN;
                            drain_d = 2'd2;
                        end
                    end
                    BUBBLE: begin
                        bub_d = bub_q - 2'd1;
                        if (bub_q == 2'd1) state_d = RUN;
                    end
                    DRAIN: begin
                        drain_d = drain_q - 2'd1;
                        if (drain_q == 2'd1) state_d = HALT;
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_comb begin
        bus.pc_stall_n     = 1'b1;
        bus.if_id_stall_n  = 1'b1;
        bus.if_id_flush    = 1'b0;
        bus.id_ex_stall_n  = 1'b1;
        bus.id_ex_flush    = 1'b0;
        bus.ex_mem_stall_n = 1'b1;
        bus.halted         = (state_q == HALT);
        if (state_q == HALT || bus.mem_busy) begin
            bus.pc_stall_n     = 1'b0;
            bus.if_id_stall_n  = 1'b0;
            bus.id_ex_stall_n  = 1'b0;
            bus.ex_mem_stall_n = 1'b0;
        end else begin
            case (eff_state)
                RUN: begin
                    if (bus.ex_branch_taken) begin
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end else if (hazard) begin
                        bus.pc_stall_n    = 1'b0;
                        bus.if_id_stall_n = 1'b0;
                        bus.id_ex_flush   = 1'b1;
                    end else if (bus.ex_opcode == OP_HLT) begin
                        bus.pc_stall_n  = 1'b0;
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end
                end
                BUBBLE: begin
                    bus.pc_stall_n    = 1'b0;
                    bus.if_id_stall_n = 1'b0;
                    bus.id_ex_flush   = 1'b1;
                end
                DRAIN: begin
                    bus.pc_stall_n  = 1'b0;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!bus.pc_stall_n && state_q != HALT && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed pipeline vectors
module tb_hazard_ctrl;
    import cpu_pkg::*;

    // {pc_stall_n, if_id_stall_n, if_id_flush, id_ex_stall_n, id_ex_flush, ex_mem_stall_n, halted}
    localparam logic [6:0] DEF  = 7'b1101010;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] HLTF = 7'b0111110;
    localparam logic [6:0] FRZ  = 7'b0000000;
    localparam logic [6:0] HLTD = 7'b0000001;

    typedef struct packed {
        logic [3:0] ex_op;
        logic [3:0] ex_rd;
        logic       ex_wr;
        logic [3:0] id_rs;
        logic [3:0] id_rt;
        logic       u_rs;
        logic       u_rt;
        logic       br;
        logic       mb;
    } stim_t;

    typedef struct {
        string       nm;
        logic [6:0]  o;
        logic [15:0] c;
    } exp_t;

    logic   clk;
    logic   rst_n;
    stim_t  s;
    exp_t   q[$];
    int     total;
    int     passed;

    hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();

    hazard_ctrl #(.LOAD_USE_BUBBLES(3), .STALL_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply();
        bus.id_opcode       = 4'h0;
        bus.ex_opcode       = s.ex_op;
        bus.ex_rd_addr      = s.ex_rd;
        bus.ex_WriteReg     = s.ex_wr;
        bus.id_rs_addr      = s.id_rs;
        bus.id_rt_addr      = s.id_rt;
        bus.id_uses_rs      = s.u_rs;
        bus.id_uses_rt      = s.u_rt;
        bus.ex_branch_taken = s.br;
        bus.mem_busy        = s.mb;
    endtask

    task automatic step(input string nm, input logic r, input logic [6:0] e, input logic [15:0] c);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r;
        apply();
        x.nm = nm;
        x.o  = e;
        x.c  = c;
        q.push_back(x);
    endtask

    task automatic lu_rs();
        s = '0;
        s.ex_op = OP_LW; s.ex_rd = 4'd3; s.ex_wr = 1'b1; s.id_rs = 4'd3; s.u_rs = 1'b1;
    endtask

    initial begin : monitor
        exp_t       x;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {bus.pc_stall_n, bus.if_id_stall_n, bus.if_id_flush, bus.id_ex_stall_n,
                       bus.id_ex_flush, bus.ex_mem_stall_n, bus.halted};
                total++;
                if (got !== x.o || bus.stall_count !== x.c)
                    $display("FAIL %s: got ctrl=%b stall_count=%h, expected ctrl=%b stall_count=%h",
                             x.nm, got, bus.stall_count, x.o, x.c);
                else
                    passed++;
            end
        end
    end

    initial begin : driver
        int waitc;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        s      = '0;
        apply();

        step("reset", 1'b0, DEF, 16'd0);
        step("idle", 1'b1, DEF, 16'd0);

        lu_rs();
        step("lu_rs", 1'b1, LU, 16'd0);
        s = '0;
        step("bub1", 1'b1, LU, 16'd1);
        step("bub2", 1'b1, LU, 16'd2);
        step("lu_done", 1'b1, DEF, 16'd3);

        lu_rs(); s.ex_rd = 4'd0; s.id_rs = 4'd0;
        step("rd_zero", 1'b1, DEF, 16'd3);
        lu_rs(); s.u_rs = 1'b0;
        step("no_use", 1'b1, DEF, 16'd3);
        lu_rs(); s.ex_wr = 1'b0;
        step("no_write", 1'b1, DEF, 16'd3);
        lu_rs(); s.ex_op = 4'h0;
        step("not_load", 1'b1, DEF, 16'd3);
        s = '0; s.ex_op = OP_LW; s.ex_rd = 4'd5; s.ex_wr = 1'b1; s.id_rt = 4'd5; s.u_rt = 1'b1;
        step("lu_rt", 1'b1, LU, 16'd3);
        s = '0;
        step("rt_bub1", 1'b1, LU, 16'd4);
        step("rt_bub2", 1'b1, LU, 16'd5);
        step("rt_done", 1'b1, DEF, 16'd6);

        lu_rs(); s.br = 1'b1;
        step("br_over_lu", 1'b1, BR, 16'd6);
        s = '0;
        step("br_after", 1'b1, DEF, 16'd6);

        lu_rs();
        step("lu_mw", 1'b1, LU, 16'd6);
        s = '0;
        step("mw_bub1", 1'b1, LU, 16'd7);
        s.mb = 1'b1;
        step("mw_frz1", 1'b1, FRZ, 16'd8);
        s.br = 1'b1;
        step("mw_frz2_br", 1'b1, FRZ, 16'd9);
        s.br = 1'b0;
        step("mw_frz3", 1'b1, FRZ, 16'd10);
        step("mw_frz4", 1'b1, FRZ, 16'd11);
        s = '0;
        step("mw_resume", 1'b1, LU, 16'd12);
        step("mw_done", 1'b1, DEF, 16'd13);
        s.mb = 1'b1; s.br = 1'b1;
        step("run_frz_br", 1'b1, FRZ, 16'd13);
        s.mb = 1'b0;
        step("br_reeval", 1'b1, BR, 16'd14);
        s = '0;
        step("br_reeval_done", 1'b1, DEF, 16'd14);

        lu_rs();
        step("lu_pre_rst", 1'b1, LU, 16'd14);
        s = '0;
        step("rst_mid_bubble", 1'b0, DEF, 16'd0);
        step("rst_rel1", 1'b1, DEF, 16'd0);

        s.ex_op = OP_HLT;
        step("hlt", 1'b1, HLTF, 16'd0);
        s = '0;
        step("drain1", 1'b1, HLTF, 16'd1);
        step("drain2", 1'b1, HLTF, 16'd2);
        step("halted", 1'b1, HLTD, 16'd3);
        s.mb = 1'b1;
        step("halt_mb", 1'b1, HLTD, 16'd3);
        lu_rs(); s.br = 1'b1;
        step("halt_br_lu", 1'b1, HLTD, 16'd3);
        s = '0; s.mb = 1'b1;
        step("halt_mb2", 1'b1, HLTD, 16'd3);
        s = '0;
        step("halt_hold", 1'b1, HLTD, 16'd3);
        step("rst_in_halt", 1'b0, DEF, 16'd0);
        step("rst_rel2", 1'b1, DEF, 16'd0);

        s.mb = 1'b1;
        for (int i = 0; i < 65540; i++)
            step("sat_frz", 1'b1, FRZ, (i >= 65535) ? 16'hFFFF : 16'(i));
        s = '0;
        step("sat_release", 1'b1, DEF, 16'hFFFF);
        lu_rs();
        step("sat_lu", 1'b1, LU, 16'hFFFF);
        s = '0;
        step("sat_hold", 1'b1, LU, 16'hFFFF);

        waitc = 0;
        while (q.size() > 0 && waitc < 10) begin
            @(posedge clk);
            waitc++;
        end
        total++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain_queue: got %0d pending, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control block that drives the stall and flush inputs of the IF_ID and ID_EX pipeline registers, and the stall inputs of EX_MEM and the PC.
- Detects load-use hazards between ID and EX and inserts bubbles.
- Flushes wrong-path instructions when EX resolves a taken branch.
- Freezes the whole pipeline while data memory is busy.
- Drains and halts the core on HLT.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
LOAD_USE_BUBBLES, 1, bubble cycles inserted per load-use hazard (legal range 1..3).
STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
id_opcode  in  4  opcode of the instruction in ID.
id_rs_addr  in  4  rs register number in ID.
id_rt_addr  in  4  rt register number in ID.
id_uses_rs  in  1  ID instruction reads rs.
id_uses_rt  in  1  ID instruction reads rt.
ex_opcode  in  4  opcode in EX.
ex_rd_addr  in  4  destination register number in EX.
ex_WriteReg  in  1  EX instruction writes the register file.
ex_branch_taken  in  1  branch in EX resolved as taken.
mem_busy  in  1  data memory has not completed; the pipeline must freeze.
pc_stall_n  out  1  0 holds the PC.
if_id_stall_n  out  1  0 holds IF_ID.
if_id_flush  out  1  1 clears IF_ID to a NOP on this edge.
id_ex_stall_n  out  1  0 holds ID_EX.
id_ex_flush  out  1  1 clears ID_EX to a bubble on this edge.
ex_mem_stall_n  out  1  0 holds EX_MEM.
halted  out  1  core halted.
stall_count  out  STALL_CNT_W  count of cycles in which pc_stall_n was 0.

Behaviour:
Opcodes: LW=4'b1000, HLT=4'b1111.

Load-use hazard (combinational), true when all of the following hold:
- ex_opcode==LW, ex_WriteReg==1 and ex_rd_addr!=0;
- and either (id_uses_rs && id_rs_addr==ex_rd_addr) or (id_uses_rt && id_rt_addr==ex_rd_addr).

FSM states: RUN, BUBBLE, MEM_WAIT, DRAIN, HALT. Registered state, bubble counter (2b), drain counter (2b).
- Default outputs: all stall_n=1, flushes=0.
- Input priority within a cycle: mem_busy > ex_branch_taken > load-use > ex_opcode==HLT.

Per-state behaviour:
- Any state except HALT, mem_busy=1:
  - All four stall_n=0, no flush.
  - Save the current state and counters; go to MEM_WAIT.
  - A branch or hazard presented in the same cycle is ignored; EX is held, so it is re-evaluated after the wait.
- MEM_WAIT: outputs as above while mem_busy=1. On mem_busy=0, return to the saved state with saved counters and evaluate that state's rules in the same cycle.
- RUN, ex_branch_taken:
  - if_id_flush=1 and id_ex_flush=1 for exactly that cycle; stay in RUN.
  - A simultaneous load-use hazard is ignored, because the ID instruction is wrong-path.
- RUN, load-use:
  - pc_stall_n=0, if_id_stall_n=0, id_ex_flush=1.
  - If LOAD_USE_BUBBLES>1, go to BUBBLE with counter=LOAD_USE_BUBBLES-1; otherwise stay in RUN.
- BUBBLE:
  - Same outputs as a load-use cycle; counter decrements each cycle.
  - Return to RUN when the counter reaches 0 on this edge.
  - Hazard re-detection is suppressed while in BUBBLE.
- RUN, ex_opcode==HLT:
  - pc_stall_n=0, if_id_flush=1, id_ex_flush=1.
  - Go to DRAIN with counter=2.
- DRAIN:
  - pc_stall_n=0, if_id_flush=1, id_ex_flush=1.
  - Counter decrements each cycle; at 0, go to HALT (HLT has retired through WB).
- HALT:
  - halted=1, all stall_n=0.
  - Absorbing until reset; mem_busy is ignored.

stall_count:
- Increments each cycle pc_stall_n==0 and state!=HALT.
- Saturates at all-ones and never wraps.

Reset (rst_n=0, asynchronous, mid-operation included):
- State=RUN; all counters 0; halted=0; stall_count=0.
- With inputs idle, outputs read stall_n=1 and flush=0.

Decomposition:
Shared package cpu_pkg holds:
- opcode localparams (LW, SW, B, BR, HLT, ...);
- hazard_state_t enum {RUN, BUBBLE, MEM_WAIT, DRAIN, HALT}.

One combinational sub-module, load_use_detect (ID/EX register compare), is instantiated once. The FSM and counters stay in hazard_ctrl.

Test Plan:
1. EX: LW r3, ex_WriteReg=1; ID: ADD using rs=r3 -> one cycle of pc_stall_n=0, if_id_stall_n=0, id_ex_flush=1, then RUN; stall_count=1.
2. Same as 1 with ex_rd_addr=0, or with id_uses_rs=0 -> no stall, no flush; stall_count stays 0.
3. ex_branch_taken=1 together with a load-use hazard -> if_id_flush=1 and id_ex_flush=1 for 1 cycle, no stall, next cycle all defaults.
4. mem_busy high for 4 cycles during BUBBLE with LOAD_USE_BUBBLES=3 -> all stall_n=0 for 4 cycles, then the remaining bubbles resume; stall_count increases by 4 plus the remaining bubbles.
5. ex_opcode=HLT -> 3 cycles of flush/stall, then halted=1 and all stall_n=0 indefinitely; mem_busy pulses have no effect.
6. rst_n pulsed low asynchronously mid-BUBBLE and in HALT -> immediate return to RUN defaults, halted=0, stall_count=0; force stall_count to saturate -> it holds at 16'hFFFF.
